// File: rtl/md_demux_pkg.sv
// Shared defaults and error-flag bit positions for the demux dispatch front end.
package md_demux_pkg;
    localparam int unsigned DATA_WIDTH    = 96;
    localparam int unsigned NUM_DEST      = 128;
    localparam int unsigned SEL_WIDTH     = 7;
    localparam int unsigned CREDIT_DEPTH  = 4;
    localparam int unsigned CREDIT_WIDTH  = 3;
    localparam int unsigned ERR_WIDTH     = 2;
    localparam int unsigned ERR_OVERFLOW  = 0;
    localparam int unsigned ERR_SEL_RANGE = 1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr, pointer moves past the winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_WIDTH-1:0] rr_ptr;
    logic [PTR_WIDTH-1:0] winner;
    logic [PTR_WIDTH-1:0] idx;
    logic                 found;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (winner == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : winner + PTR_WIDTH'(1);
        end
    end
endmodule

// File: rtl/demux_dispatch_arbiter.sv
// Credit-gated round-robin dispatcher feeding the registered input port of a demux tree.
module demux_dispatch_arbiter
    import md_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = md_demux_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned NUM_DEST     = md_demux_pkg::NUM_DEST,
    parameter int unsigned SEL_WIDTH    = md_demux_pkg::SEL_WIDTH,
    parameter int unsigned CREDIT_DEPTH = md_demux_pkg::CREDIT_DEPTH,
    parameter int unsigned CREDIT_WIDTH = md_demux_pkg::CREDIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_enable,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]  in_sel,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_DEST-1:0]           credit_return,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SEL_WIDTH-1:0]          out_sel,
    output logic                          out_valid,
    output logic [1:0]                    err_flags
);
    localparam int unsigned SEL_EXT = SEL_WIDTH + 1;

    logic [CREDIT_WIDTH-1:0] credit     [NUM_DEST];
    logic [CREDIT_WIDTH-1:0] credit_nxt [NUM_DEST];
    logic [SEL_WIDTH-1:0]    req_sel    [NUM_REQ];
    logic [NUM_REQ-1:0]      req_in_range;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant_raw;
    logic                    grant_any;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [SEL_WIDTH-1:0]    win_sel;
    logic                    win_in_range;
    logic [ERR_WIDTH-1:0]    err_set;

    // Out-of-range selects are always eligible so they can be drained and flagged.
    always_comb begin
        eligible     = '0;
        req_in_range = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_sel[i]      = in_sel[i*SEL_WIDTH +: SEL_WIDTH];
            req_in_range[i] = SEL_EXT'(req_sel[i]) < SEL_EXT'(NUM_DEST);
            eligible[i]     = in_valid[i] && in_enable &&
                              (!req_in_range[i] || (credit[req_sel[i]] != '0));
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (eligible),
        .grant (grant_raw)
    );

    assign in_ready  = rst ? '0 : grant_raw;
    assign grant_any = |in_ready;

    always_comb begin
        win_data     = '0;
        win_sel      = '0;
        win_in_range = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_ready[i]) begin
                win_data     = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_sel      = req_sel[i];
                win_in_range = req_in_range[i];
            end
        end
    end

    // Grant and return to the same destination cancel; a return to a full counter is an error.
    always_comb begin
        err_set = '0;
        err_set[ERR_SEL_RANGE] = grant_any && !win_in_range;
        for (int d = 0; d < NUM_DEST; d++) begin
            credit_nxt[d] = credit[d];
            if (credit_return[d] &&
                !(grant_any && win_in_range && (win_sel == SEL_WIDTH'(d)))) begin
                if (credit[d] == CREDIT_WIDTH'(CREDIT_DEPTH)) begin
                    err_set[ERR_OVERFLOW] = 1'b1;
                end else begin
                    credit_nxt[d] = credit[d] + CREDIT_WIDTH'(1);
                end
            end else if (!credit_return[d] &&
                         grant_any && win_in_range && (win_sel == SEL_WIDTH'(d))) begin
                credit_nxt[d] = credit[d] - CREDIT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NUM_DEST; d++) begin
                credit[d] <= CREDIT_WIDTH'(CREDIT_DEPTH);
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            err_flags <= '0;
        end else begin
            credit    <= credit_nxt;
            out_valid <= grant_any && win_in_range;
            if (grant_any && win_in_range) begin
                out_data <= win_data;
                out_sel  <= win_sel;
            end
            err_flags <= err_flags | err_set;
        end
    end
endmodule

// File: tb/tb_demux_dispatch_arbiter.sv
// Self-checking bench for demux_dispatch_arbiter against a queue-free credit/round-robin model.
module tb_demux_dispatch_arbiter;
    localparam int NR = 4;
    localparam int DW = 96;
    localparam int ND = 100;
    localparam int SW = 7;
    localparam int CD = 4;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_enable;
    logic [NR*DW-1:0] in_data;
    logic [NR*SW-1:0] in_sel;
    logic [NR-1:0]    in_valid;
    logic [NR-1:0]    in_ready;
    logic [ND-1:0]    credit_return;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_sel;
    logic             out_valid;
    logic [1:0]       err_flags;

    int checks = 0;
    int errors = 0;

    int          m_credit [ND];
    int          m_ptr;
    logic        m_ov;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_data;
    logic [1:0]  m_err;

    demux_dispatch_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .NUM_DEST    (ND),
        .SEL_WIDTH   (SW),
        .CREDIT_DEPTH(CD),
        .CREDIT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_enable    (in_enable),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .credit_return(credit_return),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .out_valid    (out_valid),
        .err_flags    (err_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) m_credit[d] = CD;
        m_ptr = 0; m_ov = 1'b0; m_sel = '0; m_data = '0; m_err = 2'b00;
    endtask

    function automatic int model_grant();
        int i, s;
        for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            s = int'(in_sel[i*SW +: SW]);
            if (in_valid[i] && in_enable && (s >= ND || m_credit[s] > 0)) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_commit(input int g);
        int s;
        m_ov = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            s = int'(in_sel[g*SW +: SW]);
            if (s < ND) begin
                m_credit[s]--;
                m_ov = 1'b1; m_sel = SW'(s); m_data = in_data[g*DW +: DW];
            end else begin
                m_err[1] = 1'b1;
            end
        end
        for (int d = 0; d < ND; d++) begin
            if (credit_return[d]) begin
                if (m_credit[d] == CD) m_err[0] = 1'b1;
                else m_credit[d]++;
            end
        end
    endtask

    // One clock edge: model follows what the DUT sampled, returns are single-cycle pulses.
    task automatic advance();
        int g;
        g = model_grant();
        @(posedge clk);
        #1;
        model_commit(g);
        credit_return = '0;
    endtask

    task automatic set_req(input int i, input logic v, input int s, input logic [DW-1:0] d);
        in_valid[i] = v;
        in_sel[i*SW +: SW] = SW'(s);
        in_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_enable = 1'b1; in_data = '0; in_sel = '0; in_valid = '0; credit_return = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1, 5, 96'h1);
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0 || out_sel !== '0) begin errors++; $display("FAIL reset_out_regs: data %h sel %0d expected 0", out_data, out_sel); end
        checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err_flags); end
        in_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        set_req(0, 1'b1, 5, 96'hA);
        #2;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", in_ready); end
        advance();
        in_valid = '0;
        checks++; if (out_valid !== 1'b1 || out_sel !== 7'd5 || out_data !== 96'hA)
            begin errors++; $display("FAIL single_out: valid %b sel %0d data %h expected 1 5 a", out_valid, out_sel, out_data); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 10 + i, rand_data());
        for (int c = 0; c < 8; c++) begin
            #2;
            exp = 4'b0001 << ((1 + c) % NR);
            checks++; if (in_ready !== exp) begin errors++; $display("FAIL rr_order cycle %0d: got %b expected %b", c, in_ready, exp); end
            advance();
            checks++; if (out_valid !== 1'b1 || out_sel !== SW'(10 + (1 + c) % NR))
                begin errors++; $display("FAIL rr_out cycle %0d: valid %b sel %0d expected 1 %0d", c, out_valid, out_sel, 10 + (1 + c) % NR); end
        end
        in_valid = '0;
    endtask

    task automatic test_credit_exhaustion();
        int n = 0;
        set_req(1, 1'b1, 9, rand_data());
        for (int c = 0; c < 6; c++) begin
            #2;
            if (in_ready[1]) n++;
            advance();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL exhaust_count: got %0d grants expected 4", n); end
        credit_return[9] = 1'b1;
        #2;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL exhaust_return_same: got %b expected 0000", in_ready); end
        advance();
        #2;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL exhaust_return_next: got %b expected 0010", in_ready); end
        advance();
        #2;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL exhaust_after: got %b expected 0000", in_ready); end
        in_valid = '0;
    endtask

    task automatic test_blocked_skip();
        set_req(0, 1'b1, 2, rand_data());
        repeat (4) begin #2; advance(); end
        in_valid = '0;
        set_req(3, 1'b1, 20, rand_data());
        #2;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL skip_setup: got %b expected 1000", in_ready); end
        advance();
        set_req(3, 1'b0, 20, '0);
        set_req(0, 1'b1, 2, rand_data());
        set_req(2, 1'b1, 3, rand_data());
        #2;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL skip_grant: got %b expected 0100", in_ready); end
        advance();
        checks++; if (out_valid !== 1'b1 || out_sel !== 7'd3) begin errors++; $display("FAIL skip_out: valid %b sel %0d expected 1 3", out_valid, out_sel); end
        set_req(0, 1'b1, 4, rand_data());
        set_req(2, 1'b0, 3, '0);
        set_req(3, 1'b1, 21, rand_data());
        #2;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL skip_ptr: got %b expected 1000", in_ready); end
        advance();
        in_valid = '0;
    endtask

    task automatic test_grant_and_return();
        int n = 0;
        set_req(1, 1'b1, 7, rand_data());
        credit_return[7] = 1'b1;
        #2;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL gr_ready: got %b expected 0010", in_ready); end
        advance();
        checks++; if (err_flags !== 2'b00) begin errors++; $display("FAIL gr_err: got %b expected 00", err_flags); end
        for (int c = 0; c < 6; c++) begin
            #2;
            if (in_ready[1]) n++;
            advance();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL gr_credit: got %0d grants expected 4", n); end
        in_valid = '0;
    endtask

    task automatic test_enable();
        set_req(2, 1'b1, 30, 96'h3C);
        #2;
        advance();
        in_enable = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL enable_ready: got %b expected 0000", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_sel !== 7'd30 || out_data !== 96'h3C)
            begin errors++; $display("FAIL enable_out: valid %b sel %0d data %h expected 1 30 3c", out_valid, out_sel, out_data); end
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enable_idle: got %b expected 0", out_valid); end
        in_enable = 1'b1;
        in_valid = '0;
    endtask

    task automatic test_errors();
        int n = 0;
        credit_return[50] = 1'b1;
        #2;
        advance();
        checks++; if (err_flags !== 2'b01) begin errors++; $display("FAIL err_overflow: got %b expected 01", err_flags); end
        set_req(0, 1'b1, 50, rand_data());
        for (int c = 0; c < 5; c++) begin
            #2;
            if (in_ready[0]) n++;
            advance();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL err_saturate: got %0d grants expected 4", n); end
        in_valid = '0;
        set_req(3, 1'b1, 127, rand_data());
        #2;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL err_range_ready: got %b expected 1000", in_ready); end
        advance();
        in_valid = '0;
        checks++; if (out_valid !== 1'b0 || err_flags !== 2'b11)
            begin errors++; $display("FAIL err_range: valid %b err %b expected 0 11", out_valid, err_flags); end
    endtask

    task automatic test_random();
        logic [NR-1:0] er;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 15) == 0) ? 127 : int'($urandom_range(0, 7)), rand_data());
            in_enable = ($urandom_range(0, 7) != 0);
            for (int d = 0; d < 8; d++) credit_return[d] = ($urandom_range(0, 3) == 0);
            #2;
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready cycle %0d: got %b expected %b", c, in_ready, er); end
            advance();
            checks++; if (out_valid !== m_ov || err_flags !== m_err)
                begin errors++; $display("FAIL rand_ctrl cycle %0d: valid %b err %b expected %b %b", c, out_valid, err_flags, m_ov, m_err); end
            if (m_ov) begin
                checks++; if (out_sel !== m_sel || out_data !== m_data)
                    begin errors++; $display("FAIL rand_payload cycle %0d: sel %0d data %h expected %0d %h", c, out_sel, out_data, m_sel, m_data); end
            end
        end
        in_valid = '0; in_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        set_req(1, 1'b1, 60, rand_data());
        #2;
        advance();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", out_valid); end
        rst = 1'b1;
        in_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || err_flags !== 2'b00 || in_ready !== 4'b0000)
            begin errors++; $display("FAIL rstmid_regs: valid %b sel %0d err %b ready %b expected all zero", out_valid, out_sel, err_flags, in_ready); end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        set_req(1, 1'b1, 9, rand_data());
        for (int c = 0; c < 5; c++) begin
            #2;
            if (in_ready[1]) n++;
            advance();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rstmid_credit: got %0d grants expected 4", n); end
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_single_grant();
        test_round_robin();
        test_credit_exhaustion();
        test_blocked_skip();
        test_grant_and_return();
        test_enable();
        test_errors();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
